// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle for the multi-cycle ALU execute unit.
// The master side issues operations and consumes results; the slave side is
// the execute unit itself.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  // request channel
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  // response channel
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, alu_control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execute unit for the 4-bit ALU control code.
// AND/OR/ADD/SUB/XOR/SLT finish one cycle after acceptance; SLL/SRL shift one
// bit per cycle (latency 1 + shamt) unless ALU_BARREL_SHIFT_EN is defined, in
// which case shifts are single-step and the SHIFT state/counter disappear.
// Results are held in DONE until the consumer takes them; a new request can be
// accepted in the same cycle the previous result is consumed.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SLL = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SLT = 4'b0111
  } alu_op_e;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;
`endif

  state_e          state_q;
  state_e          state_next;
  state_e          accept_next;

  logic            in_ready_int;
  logic            accept;

  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  // request decode results, valid whenever a request is presented
  logic [XLEN-1:0] acc_result;
  logic            acc_illegal;
  logic [SHW-1:0]  acc_shamt;
`ifndef ALU_BARREL_SHIFT_EN
  logic            acc_shift;
  logic            acc_right;
  logic [SHW-1:0]  count_q;
  logic            right_q;
`endif

  assign accept    = bus.in_valid && in_ready_int;
  assign acc_shamt = bus.op_b[SHW-1:0];

  // Decode the presented request into its first-cycle result and next state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    acc_result  = '0;
    acc_illegal = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
    acc_shift   = 1'b0;
    acc_right   = 1'b0;
`endif
    case (alu_op_e'(bus.alu_control))
      OP_AND: acc_result = bus.op_a & bus.op_b;
      OP_OR:  acc_result = bus.op_a | bus.op_b;
      OP_ADD: acc_result = bus.op_a + bus.op_b;
      OP_SUB: acc_result = bus.op_a - bus.op_b;
      OP_XOR: acc_result = bus.op_a ^ bus.op_b;
      OP_SLT: acc_result = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: acc_result = bus.op_a << acc_shamt;
      OP_SRL: acc_result = bus.op_a >> acc_shamt;
`else
      // iterative shifts start from op_a; a zero amount completes immediately
      OP_SLL: begin
        acc_result = bus.op_a;
        acc_shift  = (acc_shamt != '0);
      end
      OP_SRL: begin
        acc_result = bus.op_a;
        acc_shift  = (acc_shamt != '0);
        acc_right  = 1'b1;
      end
`endif
      default: acc_illegal = 1'b1;
    endcase
  end

  // Where an accepted request goes next.
  always_comb begin
`ifdef ALU_BARREL_SHIFT_EN
    accept_next = S_DONE;
`else
    accept_next = acc_shift ? S_SHIFT : S_DONE;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it only appears inside the clocked block.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_next = accept_next;
      end
`ifndef ALU_BARREL_SHIFT_EN
      S_SHIFT: begin
        if (count_q == SHW'(1)) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        if (accept)              state_next = accept_next;
        else if (bus.out_ready)  state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: handshake flags.
  always_comb begin
    in_ready_int  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    bus.out_valid = (state_q == S_DONE);
  end

  assign bus.in_ready = in_ready_int;

  // Datapath: capture on accept, iterate while shifting, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      count_q   <= '0;
      right_q   <= 1'b0;
`endif
    end else if (accept) begin
      result_q  <= acc_result;
      illegal_q <= acc_illegal;
`ifndef ALU_BARREL_SHIFT_EN
      count_q   <= acc_shamt;
      right_q   <= acc_right;
    end else if (state_q == S_SHIFT) begin
      result_q  <= right_q ? (result_q >> 1) : (result_q << 1);
      count_q   <= count_q - SHW'(1);
`endif
    end
  end

  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;
  assign bus.zero    = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: self-checking bench for alu_exec_unit. A table of
// directed vectors, hand-written sequences for backpressure, requests held
// during a shift and reset mid-operation, then randomized operations checked
// against an arithmetic reference model. Honours ALU_BARREL_SHIFT_EN for the
// expected shift latency.
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          stall;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the operation definitions.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill);
    int sh;
    sh  = int'(b[4:0]);
    ill = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a - b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        r   = 32'd0;
        ill = 1'b1;
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (op == 4'd5 || op == 4'd6) return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  // Issue one operation, measure latency, check the result and its hold period.
  // Leaves out_ready high so the result is consumed on the next edge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill,
                        input int stall);
    int edges;
    int rdy_hi;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.op_a        = a;
    bus.op_b        = b;
    #1;
    edges = 0;
    while (!bus.in_ready && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = (stall == 0);
    edges  = 1;
    rdy_hi = 0;
    while (!bus.out_valid && edges < 100) begin
      if (bus.in_ready) rdy_hi++;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(exp_latency(op, b)));
    check({tag, " busy in_ready"}, 32'(rdy_hi), 32'd0);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " zero"}, 32'(bus.zero), 32'(exp_res == 32'd0));
    check({tag, " illegal"}, 32'(bus.illegal), 32'(exp_ill));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, " hold result"}, bus.result, exp_res);
      check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] r;
    logic        ill;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          edges;
    int          seen;

    total = 0;
    bad   = 0;

    vecs = '{
      '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0},
      '{4'b0011, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 0},
      '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0},
      '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1},
      '{4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 0},
      '{4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 0},
      '{4'b0101, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 0},
      '{4'b0110, 32'hF000_000F, 32'h0000_0004, 32'h0F00_0000, 1'b0, 2},
      '{4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 0},
      '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 0},
      '{4'b0001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 0},
      '{4'b0100, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 0}
    };

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.alu_control = 4'd0;
    bus.op_a        = 32'd0;
    bus.op_b        = 32'd0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset result", bus.result, 32'd0);
    check("reset zero", 32'(bus.zero), 32'd1);
    check("reset illegal", 32'(bus.illegal), 32'd0);

    // directed table
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].ill, vecs[i].stall);

    // backpressure on XOR, then AND accepted in the consume cycle
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_control = 4'b0100;
    bus.op_a = 32'h0000_F0F0; bus.op_b = 32'h0000_0FF0;
    edges = 0;
    while (!bus.in_ready && edges < 100) begin @(posedge clk); #1; edges++; end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp valid", 32'(bus.out_valid), 32'd1);
    check("bp result", bus.result, 32'h0000_FF00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold result", bus.result, 32'h0000_FF00);
      check("bp hold in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b1; bus.alu_control = 4'b0000;
    bus.op_a = 32'h0000_FF00; bus.op_b = 32'h0000_0FF0;
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp and valid", 32'(bus.out_valid), 32'd1);
    check("bp and result", bus.result, 32'h0000_0F00);

    // request held while shifting is not consumed until the shift result is taken
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_control = 4'b0101;
    bus.op_a = 32'h0000_0003; bus.op_b = 32'h0000_0004;
    edges = 0;
    while (!bus.in_ready && edges < 100) begin @(posedge clk); #1; edges++; end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.alu_control = 4'b0010; bus.op_a = 32'd2; bus.op_b = 32'd3;
    edges = 0;
    seen  = 0;
    while (!bus.out_valid && edges < 100) begin
      if (bus.in_ready) seen++;
      @(posedge clk); #1;
      edges++;
    end
    check("held req in_ready", 32'(seen), 32'd0);
    check("held req shift result", bus.result, 32'h0000_0030);
    bus.out_ready = 1'b1;
    #1;
    check("held req accept ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("held req add result", bus.result, 32'd5);
    check("held req add valid", 32'(bus.out_valid), 32'd1);

    // reset on cycle 3 of SRL by 10
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.alu_control = 4'b0110;
    bus.op_a = 32'hFFFF_0000; bus.op_b = 32'd10;
    edges = 0;
    while (!bus.in_ready && edges < 100) begin @(posedge clk); #1; edges++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("rst no late completion", 32'(seen), 32'd0);

    // randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 9));
      if (op > 4'd7) op = 4'($urandom_range(8, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = a;
        default: ;
      endcase
      model(op, a, b, r, ill);
      run_op($sformatf("rnd%0d", n), op, a, b, r, ill, int'($urandom_range(0, 2)));
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two operands, and returns the result. It sits in the EX stage between the decode/operand-fetch logic and writeback. Both sides use valid/ready handshakes. Shifts are iterative (one bit per cycle) unless the barrel-shifter option is compiled in.

## Interface
- XLEN, 32, operand/result width; SHW = $clog2(XLEN) shift-amount bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request this cycle.
- alu_control  in  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT (signed); all other codes invalid.
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2 or immediate); shift amount = op_b[SHW-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- zero  out  1  result == 0.
- illegal  out  1  request carried an invalid op code.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- A request is accepted when in_valid && in_ready. On acceptance, op code, operands and shift count are captured in registers. Inputs are ignored at all other times.
- in_ready = (state == IDLE) || (state == DONE && out_ready), which allows back-to-back operations.
- On accept of AND/OR/ADD/SUB/XOR/SLT: compute into result and go to DONE.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT returns 1 if $signed(op_a) < $signed(op_b), else 0.
- On accept of SLL/SRL:
  - If shamt == 0: result = op_a and go to DONE.
  - Otherwise: result = op_a, count = shamt, go to SHIFT.
  - SRL is logical (zero fill).
- SHIFT: each cycle shift result by 1 in the captured direction and decrement count. When count reaches 1 (i.e. the last shift is applied this cycle), go to DONE.
- On accept of an invalid code: result = 0, illegal = 1, go to DONE.
- DONE: out_valid = 1. result, zero and illegal are held stable until out_ready.
  - out_ready && in_valid: new accept, same transitions as IDLE.
  - out_ready && !in_valid: go to IDLE.
- illegal is cleared on the next accepted legal op.
- zero is derived combinationally from the result register.

## Timing
- Reset values: state = IDLE, result = 0, illegal = 0, out_valid = 0, in_ready = 1. zero = 1 as a consequence of result = 0.
- Non-shift/invalid ops: out_valid asserts 1 cycle after the accept edge.
- Iterative shift latency = 1 + shamt cycles (shamt = 0 → 1 cycle; shamt = 31 → 32 cycles).
- Throughput with out_ready tied high: one non-shift op per cycle.
- out_valid stays high until the handshake completes. result must not change while out_valid && !out_ready.
- rst asserted mid-SHIFT or in DONE: the unit returns to IDLE on that edge and the pending result is discarded. No out_valid pulse follows.
- in_valid while in SHIFT: in_ready = 0; the request is not consumed.

## Configuration
- ALU_BARREL_SHIFT_EN:
  - Defined: SLL/SRL are computed in one step in IDLE/DONE acceptance, the SHIFT state and counter are not instantiated, and all ops have 1-cycle latency.
  - Undefined: iterative shifter as described above.

## Test plan
- Reset then idle: out_valid = 0, in_ready = 1, result = 0, zero = 1, illegal = 0.
- ADD 0xFFFFFFFF + 1 with out_ready = 1 → 1 cycle later result = 0, zero = 1. Then SUB 5 − 7 → result = 0xFFFFFFFE. SLT −1 < 1 → result = 1.
- SLL op_a = 0x1, shamt = 31 (iterative build) → out_valid exactly 32 cycles after accept, result = 0x80000000, in_ready = 0 throughout. With ALU_BARREL_SHIFT_EN → 1 cycle.
- Backpressure: XOR 0xF0F0 ^ 0x0FF0 with out_ready = 0 for 5 cycles → result = 0xFF00 held stable, in_ready = 0. Raising out_ready together with in_valid (AND) accepts the new op the same cycle.
- alu_control = 1111 → result = 0, illegal = 1. A following ORI-style OR 0x1 | 0x2 → result = 3, illegal = 0.
- rst asserted on cycle 3 of SRL shamt = 10 → next cycle state IDLE, out_valid = 0, result = 0, with no late completion.
